pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage RISC-V pipeline.
- Arbitrates four hazard sources: data-memory wait, multi-cycle MUL/DIV occupancy of EX, taken-branch redirect, and load-use.
- Drives per-stage write enables and bubble/flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Replaces ad-hoc combinational stall logic with one registered FSM plus a latency counter.

---
 rtl/pipe_hazard_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: arbitrates dmem wait, MUL/DIV occupancy, branch redirect, load-use.
// Latency: outputs are combinational from registered state/counter and current inputs; state advances each clk.
// Backpressure: dmem wait freezes the whole pipe; MDU freezes PC..ID/EX and bubbles EX/MEM for MDU_LAT-1 cycles.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ifid_rs1/ifid_rs2          source registers of the instruction in ID
//   idex_memread/idex_rd       load-in-EX flag and its destination register
//   idex_mdu                   instruction in EX is MUL/DIV
//   ex_branch_taken            EX redirects the fetch stream
//   dmem_req/dmem_ready        MEM-stage access outstanding / completing
//   *_write, *_bubble, *_flush per-stage register controls
//   mdu_start                  one-cycle start pulse to the MUL/DIV unit
//   state_o                    0 RUN, 1 MDU_BUSY, 2 MEM_WAIT
// Optional: define PIPE_HAZARD_PERF_EN to add saturating 32-bit stall counters
//   perf_lu_stalls, perf_mdu_stalls, perf_mem_stalls.
// MDU_LAT must lie in 2..8 and fit CNT_W (2^CNT_W >= MDU_LAT).

module pipe_hazard_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] ifid_rs1,
  input  logic [4:0] ifid_rs2,
  input  logic       idex_memread,
  input  logic [4:0] idex_rd,
  input  logic       idex_mdu,
  input  logic       ex_branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_write,
  output logic       idex_bubble,
  output logic       exmem_write,
  output logic       exmem_bubble,
  output logic       memwb_bubble,
  output logic       mdu_start,
  output logic [1:0] state_o
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0] perf_lu_stalls,
  output logic [31:0] perf_mdu_stalls,
  output logic [31:0] perf_mem_stalls
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MDU_BUSY = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             lu;
  logic             run_eval;    // apply the RUN rules below the dmem check
  logic             lu_bubble;   // an LU bubble is being inserted this cycle
  logic             mem_frozen;  // a MEM_WAIT cycle with the access still pending

  // x0 is hardwired zero, so a load to x0 never creates a dependency.
  assign lu = idex_memread && (idex_rd != 5'd0) &&
              ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  assign state_o = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_bubble  = 1'b0;
    exmem_write  = 1'b1;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;
    mdu_start    = 1'b0;
    state_nxt    = state;
    cnt_nxt      = cnt;
    run_eval     = 1'b0;
    lu_bubble    = 1'b0;
    mem_frozen   = 1'b0;

    if (!rst_n) begin
      // Reset forces the outputs directly so nothing leaks while rst_n is low.
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_write   = 1'b0;
      idex_bubble  = 1'b1;
      exmem_write  = 1'b0;
      exmem_bubble = 1'b1;
      memwb_bubble = 1'b1;
      state_nxt    = RUN;
      cnt_nxt      = '0;
    end else begin
      unique case (state)
        RUN: begin
          if (dmem_req && !dmem_ready) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            state_nxt    = MEM_WAIT;
          end else begin
            run_eval = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!dmem_ready) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
            mem_frozen   = 1'b1;
          end else begin
            // Completion cycle behaves like RUN (minus the dmem check).
            state_nxt = RUN;
            run_eval  = 1'b1;
          end
        end
        MDU_BUSY: begin
          // Branch and LU are not examined: EX still holds the MDU op.
          if (cnt != '0) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_bubble = 1'b1;
            cnt_nxt      = cnt - CNT_W'(1);
          end else begin
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase

      if (run_eval) begin
        if (idex_mdu) begin
          // Start cycle counts as the first of MDU_LAT; the release cycle is the last.
          mdu_start    = 1'b1;
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          exmem_bubble = 1'b1;
          cnt_nxt      = CNT_W'(MDU_LAT - 2);
          state_nxt    = MDU_BUSY;
        end else if (ex_branch_taken) begin
          // The dependent instruction is squashed, so LU is moot here.
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (lu) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
          lu_bubble   = 1'b1;
        end
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_lu_stalls  <= '0;
      perf_mdu_stalls <= '0;
      perf_mem_stalls <= '0;
    end else begin
      if (lu_bubble && (perf_lu_stalls != '1))
        perf_lu_stalls <= perf_lu_stalls + 32'd1;
      if ((state == MDU_BUSY) && (perf_mdu_stalls != '1))
        perf_mdu_stalls <= perf_mdu_stalls + 32'd1;
      if (mem_frozen && (perf_mem_stalls != '1))
        perf_mem_stalls <= perf_mem_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (MDU_LAT=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// Control vector order: pc_w, ifid_w, ifid_flush, idex_w, idex_bub, exmem_w, exmem_bub, memwb_bub, mdu_start.

module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ifid_rs1, ifid_rs2, idex_rd;
  logic       idex_memread, idex_mdu, ex_branch_taken, dmem_req, dmem_ready;
  logic       pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic       exmem_write, exmem_bubble, memwb_bubble, mdu_start;
  logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_lu_stalls, perf_mdu_stalls, perf_mem_stalls;
`endif

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] C_RST  = 9'b001010110;
  localparam logic [8:0] C_NORM = 9'b110101000;
  localparam logic [8:0] C_LU   = 9'b000111000;
  localparam logic [8:0] C_MDUS = 9'b000001101;
  localparam logic [8:0] C_MDUF = 9'b000001100;
  localparam logic [8:0] C_MEMF = 9'b000000010;
  localparam logic [8:0] C_BR   = 9'b111111000;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MDU_LAT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2),
    .idex_memread(idex_memread), .idex_rd(idex_rd), .idex_mdu(idex_mdu),
    .ex_branch_taken(ex_branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_bubble(idex_bubble),
    .exmem_write(exmem_write), .exmem_bubble(exmem_bubble),
    .memwb_bubble(memwb_bubble), .mdu_start(mdu_start), .state_o(state_o)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_lu_stalls(perf_lu_stalls), .perf_mdu_stalls(perf_mdu_stalls),
    .perf_mem_stalls(perf_mem_stalls)
`endif
  );

  task automatic chk(input string tag, input logic [8:0] ctl_exp, input logic [1:0] st_exp);
    logic [10:0] obs;
    logic [10:0] exp;
    obs = {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble,
           exmem_write, exmem_bubble, memwb_bubble, mdu_start, state_o};
    exp = {ctl_exp, st_exp};
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ifid_rs1 = 5'd0; ifid_rs2 = 5'd0; idex_rd = 5'd0;
    idex_memread = 1'b0; idex_mdu = 1'b0; ex_branch_taken = 1'b0;
    dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance to the next falling edge; caller then drives inputs and checks.
  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #1 chk("reset", C_RST, 2'd0);

    step(); rst_n = 1'b1; #1 chk("post_reset_idle", C_NORM, 2'd0);

    // Load-use through rs2, then clears
    step(); idex_memread = 1'b1; idex_rd = 5'd5; ifid_rs2 = 5'd5; #1 chk("lu_rs2", C_LU, 2'd0);
    step(); idle(); #1 chk("lu_clear", C_NORM, 2'd0);

    // Load-use through rs1; non-matching load does not stall
    step(); idex_memread = 1'b1; idex_rd = 5'd7; ifid_rs1 = 5'd7; #1 chk("lu_rs1", C_LU, 2'd0);
    step(); ifid_rs1 = 5'd8; ifid_rs2 = 5'd9; #1 chk("lu_nomatch", C_NORM, 2'd0);
    step(); idex_rd = 5'd5; ifid_rs2 = 5'd5; idex_memread = 1'b0; #1 chk("match_not_load", C_NORM, 2'd0);

    // Load to x0 never stalls
    step(); idle(); idex_memread = 1'b1; idex_rd = 5'd0; ifid_rs1 = 5'd0; #1 chk("x0_load", C_NORM, 2'd0);

    // Branch beats load-use
    step(); idle(); idex_memread = 1'b1; idex_rd = 5'd3; ifid_rs1 = 5'd3; ex_branch_taken = 1'b1;
    #1 chk("branch_over_lu", C_BR, 2'd0);

    // MDU occupancy, MDU_LAT=4; branch/LU ignored while busy
    step(); idle(); idex_mdu = 1'b1; #1 chk("mdu_c0", C_MDUS, 2'd0);
    step(); ex_branch_taken = 1'b1; idex_memread = 1'b1; idex_rd = 5'd4; ifid_rs1 = 5'd4;
    #1 chk("mdu_c1_ignore", C_MDUF, 2'd1);
    step(); idle(); idex_mdu = 1'b1; #1 chk("mdu_c2", C_MDUF, 2'd1);
    step(); #1 chk("mdu_c3_release", C_NORM, 2'd1);
    step(); idex_mdu = 1'b0; #1 chk("mdu_c4_run", C_NORM, 2'd0);

    // Memory wait: three frozen cycles then the ready cycle advances
    step(); idle(); dmem_req = 1'b1; #1 chk("mem_c0", C_MEMF, 2'd0);
    step(); #1 chk("mem_c1", C_MEMF, 2'd2);
    step(); #1 chk("mem_c2", C_MEMF, 2'd2);
    step(); dmem_ready = 1'b1; #1 chk("mem_ready", C_NORM, 2'd2);
    step(); idle(); #1 chk("mem_back_run", C_NORM, 2'd0);

    // Branch during memory wait stays frozen, flushes on ready
    step(); dmem_req = 1'b1; ex_branch_taken = 1'b1; #1 chk("br_mem_c0", C_MEMF, 2'd0);
    step(); #1 chk("br_mem_c1", C_MEMF, 2'd2);
    step(); dmem_ready = 1'b1; #1 chk("br_mem_ready", C_BR, 2'd2);
    step(); idle(); #1 chk("br_mem_run", C_NORM, 2'd0);

    // Ready cycle with an MDU op in EX starts the MDU directly
    step(); dmem_req = 1'b1; #1 chk("mm_c0", C_MEMF, 2'd0);
    step(); dmem_ready = 1'b1; idex_mdu = 1'b1; #1 chk("mm_ready_start", C_MDUS, 2'd2);
    step(); dmem_req = 1'b0; dmem_ready = 1'b0; #1 chk("mm_busy1", C_MDUF, 2'd1);
    step(); #1 chk("mm_busy2", C_MDUF, 2'd1);
    step(); #1 chk("mm_release", C_NORM, 2'd1);
    step(); idle(); #1 chk("mm_run", C_NORM, 2'd0);

    // Reset mid-MDU: immediate reset outputs, no start after release
    step(); idex_mdu = 1'b1; #1 chk("rm_start", C_MDUS, 2'd0);
    step(); #1 chk("rm_busy1", C_MDUF, 2'd1);
    #1 rst_n = 1'b0;
    #1 chk("rm_async_reset", C_RST, 2'd0);
    step(); rst_n = 1'b1; idex_mdu = 1'b0; #1 chk("rm_released", C_NORM, 2'd0);
    step(); #1 chk("rm_settled", C_NORM, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
